// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: frames SPI byte traffic into committed stepgen configuration.
// Snapshots positions/inputs at frame start, serves them back byte by byte on
// MISO, stages the received bytes and commits them only for full-length frames.
module spi_frame_ctrl #(
  parameter int W  = 10,
  parameter int F  = 11,
  parameter int T  = 4,
  parameter int NB = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  input  logic [4*(W+F)-1:0]   pos_in,
  input  logic [15:0]          din,
  output logic [7:0]           tx_byte,
  output logic [4*(F+1)-1:0]   vel_out,
  output logic [13:0]          dout_out,
  output logic [T-1:0]         dirtime,
  output logic [T-1:0]         steptime,
  output logic [1:0]           tap,
  output logic                 spolarity,
  output logic                 commit,
  output logic                 frame_err,
  output logic                 wdt_kick
);

  localparam int PW = W + F;
  localparam int VW = F + 1;
  localparam logic [4:0] NB5 = 5'(NB);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_RECV, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_byte_cnt;
  logic [7:0]          r_stage [0:11];
  logic [4*PW-1:0]     r_snap_pos;
  logic [15:0]         r_snap_din;
  logic [4*VW-1:0]     r_vel;
  logic [13:0]         r_dout;
  logic [T-1:0]        r_dirtime;
  logic [T-1:0]        r_steptime;
  logic [1:0]          r_tap;
  logic                r_spolarity;
  logic                r_commit;
  logic                r_frame_err;
  logic                r_wdt_kick;
  logic [4*VW-1:0]     w_stage_vel;
  logic [15:0]         w_vel16;
  logic [31:0]         w_ax;
  logic [7:0]          w_tx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state; frame_start overrides everything and restarts the frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_IDLE;
      S_SNAP: w_next = S_RECV;
      S_RECV: if (frame_end) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (frame_start) w_next = S_SNAP;
  end

  // Velocities unpacked from the staged little-endian byte pairs.
  always_comb begin
    w_stage_vel = '0;
    w_vel16     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_vel16 = {r_stage[2*k+1], r_stage[2*k]};
      w_stage_vel[k*VW +: VW] = w_vel16[VW-1:0];
    end
  end

  // MISO byte selected from the frame-start snapshot by the current index.
  always_comb begin
    w_tx = '0;
    w_ax = '0;
    if (r_byte_cnt >= NB5) begin
      w_tx = {3'b000, r_byte_cnt};
    end else if (r_byte_cnt < 5'd16) begin
      for (int unsigned k = 0; k < 4; k++)
        if (r_byte_cnt[3:2] == k[1:0]) w_ax[PW-1:0] = r_snap_pos[k*PW +: PW];
      case (r_byte_cnt[1:0])
        2'd0:    w_tx = w_ax[7:0];
        2'd1:    w_tx = w_ax[15:8];
        2'd2:    w_tx = w_ax[23:16];
        default: w_tx = '0;
      endcase
    end else if (r_byte_cnt == 5'd16) begin
      w_tx = r_snap_din[7:0];
    end else if (r_byte_cnt == 5'd17) begin
      w_tx = r_snap_din[15:8];
    end
  end

  // Datapath: snapshot, byte staging, commit/error pulses and live config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt  <= '0;
      r_snap_pos  <= '0;
      r_snap_din  <= '0;
      r_vel       <= '0;
      r_dout      <= '0;
      r_dirtime   <= '0;
      r_steptime  <= '0;
      r_tap       <= '0;
      r_spolarity <= 1'b0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wdt_kick  <= 1'b0;
      for (int unsigned i = 0; i < 12; i++) r_stage[i] <= '0;
    end else begin
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wdt_kick  <= 1'b0;
      if (frame_start) begin
        for (int unsigned i = 0; i < 12; i++) r_stage[i] <= '0;
        if (r_state == S_RECV) r_frame_err <= 1'b1;
      end
      case (r_state)
        S_SNAP: begin
          r_snap_pos <= pos_in;
          r_snap_din <= din;
          r_byte_cnt <= '0;
        end
        S_RECV: begin
          if (rx_valid && !frame_start) begin
            if (r_byte_cnt < 5'd12) r_stage[r_byte_cnt[3:0]] <= rx_byte;
            if (r_byte_cnt != 5'd31) r_byte_cnt <= r_byte_cnt + 5'd1;
          end
        end
        S_DONE: begin
          if (r_byte_cnt == NB5) begin
            r_commit    <= 1'b1;
            r_wdt_kick  <= r_stage[9][6];
            r_vel       <= w_stage_vel;
            r_dout      <= {r_stage[9][5:0], r_stage[8]};
            r_spolarity <= r_stage[10][7];
            r_dirtime   <= r_stage[10][T-1:0];
            r_tap       <= r_stage[11][7:6];
            r_steptime  <= r_stage[11][T-1:0];
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_byte   = w_tx;
  assign vel_out   = r_vel;
  assign dout_out  = r_dout;
  assign dirtime   = r_dirtime;
  assign steptime  = r_steptime;
  assign tap       = r_tap;
  assign spolarity = r_spolarity;
  assign commit    = r_commit;
  assign frame_err = r_frame_err;
  assign wdt_kick  = r_wdt_kick;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl with hand-computed expectations.
module tb_spi_frame_ctrl;
  localparam int W = 10, F = 11, T = 4, NB = 20;
  localparam int PW = W + F, VW = F + 1;

  logic clk, rst_n, frame_start, frame_end, rx_valid;
  logic [7:0] rx_byte;
  logic [4*PW-1:0] pos_in;
  logic [15:0] din;
  logic [7:0] tx_byte;
  logic [4*VW-1:0] vel_out;
  logic [13:0] dout_out;
  logic [T-1:0] dirtime, steptime;
  logic [1:0] tap;
  logic spolarity, commit, frame_err, wdt_kick;

  int checks = 0;
  int failures = 0;
  logic [7:0] fb [0:19];

  spi_frame_ctrl #(.W(W), .F(F), .T(T), .NB(NB)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .pos_in(pos_in), .din(din),
    .tx_byte(tx_byte), .vel_out(vel_out), .dout_out(dout_out), .dirtime(dirtime),
    .steptime(steptime), .tap(tap), .spolarity(spolarity), .commit(commit),
    .frame_err(frame_err), .wdt_kick(wdt_kick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
  endtask

  task automatic send_bytes(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      rx_valid = 1'b1; rx_byte = fb[i]; tick();
      rx_valid = 1'b0; tick();
    end
  endtask

  task automatic end_frame();
    frame_end = 1'b1; tick();
    frame_end = 1'b0;
  endtask

  task automatic fill_a();
    for (int i = 0; i < 20; i++) fb[i] = 8'hEE;
    fb[0] = 8'h34; fb[1] = 8'h12; fb[2] = 8'h78; fb[3] = 8'h56;
    fb[4] = 8'h00; fb[5] = 8'h00; fb[6] = 8'h00; fb[7] = 8'h00;
    fb[8] = 8'hFF; fb[9] = 8'h43; fb[10] = 8'h8A; fb[11] = 8'h45;
  endtask

  task automatic fill_d();
    for (int i = 0; i < 20; i++) fb[i] = 8'h77;
    fb[0] = 8'h01; fb[1] = 8'h0A; fb[2] = 8'h11; fb[3] = 8'h02;
    fb[4] = 8'h22; fb[5] = 8'h03; fb[6] = 8'h33; fb[7] = 8'h04;
    fb[8] = 8'h55; fb[9] = 8'h00; fb[10] = 8'h03; fb[11] = 8'hC9;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 0; frame_end = 0; rx_valid = 0; rx_byte = 0;
    pos_in = '0; din = '0;
    tick(); tick();
    checks++; if (vel_out !== '0) begin failures++; $display("FAIL reset_vel got=%h exp=0", vel_out); end
    checks++; if ({dout_out, dirtime, steptime, tap, spolarity} !== '0) begin failures++; $display("FAIL reset_cfg got=%h exp=0", {dout_out, dirtime, steptime, tap, spolarity}); end
    checks++; if ({commit, frame_err, wdt_kick} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {commit, frame_err, wdt_kick}); end
    rst_n = 1'b1; tick();
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", tx_byte); end
  endtask

  task automatic test_commit();
    fill_a();
    start_frame(); send_bytes(0, 20); end_frame();
    checks++; if (commit !== 1'b0 || vel_out !== '0) begin failures++; $display("FAIL commit_early got commit=%b vel=%h exp 0/0", commit, vel_out); end
    tick();
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL commit_pulse got=%b exp=1", commit); end
    checks++; if (vel_out !== 48'h000000678234) begin failures++; $display("FAIL commit_vel got=%h exp=000000678234", vel_out); end
    checks++; if (dout_out !== 14'h03FF) begin failures++; $display("FAIL commit_dout got=%h exp=03ff", dout_out); end
    checks++; if (wdt_kick !== 1'b1 || frame_err !== 1'b0) begin failures++; $display("FAIL commit_wdt got wdt=%b err=%b exp 1/0", wdt_kick, frame_err); end
    checks++; if ({spolarity, dirtime, tap, steptime} !== {1'b1, 4'hA, 2'd1, 4'h5}) begin failures++; $display("FAIL commit_cfg got=%h exp=%h", {spolarity, dirtime, tap, steptime}, {1'b1, 4'hA, 2'd1, 4'h5}); end
    tick();
    checks++; if (commit !== 1'b0 || wdt_kick !== 1'b0) begin failures++; $display("FAIL commit_one_cycle got commit=%b wdt=%b exp 0/0", commit, wdt_kick); end
  endtask

  task automatic test_short();
    for (int i = 0; i < 20; i++) fb[i] = 8'hFF;
    start_frame(); send_bytes(0, 19); end_frame(); tick();
    checks++; if (frame_err !== 1'b1 || commit !== 1'b0) begin failures++; $display("FAIL short_err got err=%b commit=%b exp 1/0", frame_err, commit); end
    checks++; if (vel_out !== 48'h000000678234 || dout_out !== 14'h03FF) begin failures++; $display("FAIL short_hold got vel=%h dout=%h exp 000000678234/03ff", vel_out, dout_out); end
    tick();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL short_one_cycle got=%b exp=0", frame_err); end
  endtask

  task automatic test_back_to_back_end();
    fill_a(); fb[0] = 8'hBC; fb[1] = 8'h0F;
    start_frame(); send_bytes(0, 19);
    rx_valid = 1'b1; rx_byte = fb[19]; frame_end = 1'b1; tick();
    rx_valid = 1'b0; frame_end = 1'b0; tick();
    checks++; if (commit !== 1'b1 || frame_err !== 1'b0) begin failures++; $display("FAIL coincident_commit got commit=%b err=%b exp 1/0", commit, frame_err); end
    checks++; if (vel_out !== 48'h000000678FBC) begin failures++; $display("FAIL coincident_vel got=%h exp=000000678fbc", vel_out); end
    tick();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 20; i++) fb[i] = 8'h99;
    start_frame(); send_bytes(0, 7);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++; if (frame_err !== 1'b1 || commit !== 1'b0) begin failures++; $display("FAIL abort_err got err=%b commit=%b exp 1/0", frame_err, commit); end
    checks++; if (vel_out !== 48'h000000678FBC) begin failures++; $display("FAIL abort_hold got=%h exp=000000678fbc", vel_out); end
    tick();
    fill_d(); send_bytes(0, 20); end_frame(); tick();
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL abort_new_commit got=%b exp=1", commit); end
    checks++; if (vel_out !== 48'h433322211A01) begin failures++; $display("FAIL abort_new_vel got=%h exp=433322211a01", vel_out); end
    checks++; if ({dout_out, wdt_kick, spolarity, dirtime, tap, steptime} !== {14'h0055, 1'b0, 1'b0, 4'h3, 2'd3, 4'h9}) begin failures++; $display("FAIL abort_new_cfg got=%h exp=%h", {dout_out, wdt_kick, spolarity, dirtime, tap, steptime}, {14'h0055, 1'b0, 1'b0, 4'h3, 2'd3, 4'h9}); end
    tick();
  endtask

  task automatic test_tx_snapshot();
    logic [7:0] exp_tx [0:20];
    exp_tx = '{8'hDE, 8'hBC, 8'h1A, 8'h00, 8'h45, 8'h23, 8'h01, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h1F, 8'h00,
               8'h5A, 8'hA5, 8'h00, 8'h00, 8'h14};
    pos_in = {21'h1FFFFF, 21'h000000, 21'h012345, 21'h1ABCDE};
    din = 16'hA55A;
    fill_a();
    start_frame();
    pos_in = '0; din = 16'h0000;
    for (int i = 0; i <= 20; i++) begin
      checks++;
      if (tx_byte !== exp_tx[i]) begin failures++; $display("FAIL tx_idx%0d got=%h exp=%h", i, tx_byte, exp_tx[i]); end
      if (i < 20) send_bytes(i, 1);
    end
    end_frame(); tick();
    checks++; if (commit !== 1'b1 || vel_out !== 48'h000000678234) begin failures++; $display("FAIL tx_frame_commit got commit=%b vel=%h exp 1/000000678234", commit, vel_out); end
    tick();
  endtask

  task automatic test_reset_midframe();
    fill_d();
    start_frame(); send_bytes(0, 10);
    rst_n = 1'b0; #2;
    checks++; if (vel_out !== '0 || dout_out !== '0) begin failures++; $display("FAIL rst_mid_out got vel=%h dout=%h exp 0/0", vel_out, dout_out); end
    checks++; if ({spolarity, tap, dirtime, steptime} !== '0) begin failures++; $display("FAIL rst_mid_cfg got=%h exp=0", {spolarity, tap, dirtime, steptime}); end
    rst_n = 1'b1; tick();
    end_frame(); tick();
    checks++; if (commit !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rst_mid_end got commit=%b err=%b exp 0/0", commit, frame_err); end
    tick();
    checks++; if (commit !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rst_mid_end2 got commit=%b err=%b exp 0/0", commit, frame_err); end
    rx_valid = 1'b1; rx_byte = 8'h55; tick(); rx_valid = 1'b0; tick();
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL idle_rx_ignored got=%h exp=00", tx_byte); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_short();
    test_back_to_back_end();
    test_abort();
    test_tx_snapshot();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
